// File: rtl/alarm_ring_if.sv
// alarm_ring_if: bundles the alarm controller's time, alarm, key and buzzer
// signals so the controller and its driver share one connection.
//   master : drives time/alarm/key inputs, observes buzzer status
//   slave  : the alarm_ring_ctrl side
// Signals:
//   sec_tick          1-cycle pulse per second
//   cur_hour/min/sec  running time, binary
//   alm_hour/min      stored alarm time, binary
//   alm_en            alarm armed
//   mode_ring_ad      alarm-adjust mode, inhibits new rings
//   key_stop_flag     debounced stop press pulse
//   key_snooze_flag   debounced snooze press pulse
//   buzzer, ringing, snoozing, snooze_num  registered controller status
interface alarm_ring_if;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic       alm_en;
  logic       mode_ring_ad;
  logic       key_stop_flag;
  logic       key_snooze_flag;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_num;

  modport master (
    output sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           alm_en, mode_ring_ad, key_stop_flag, key_snooze_flag,
    input  buzzer, ringing, snoozing, snooze_num
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
           alm_en, mode_ring_ad, key_stop_flag, key_snooze_flag,
    output buzzer, ringing, snoozing, snooze_num
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm scheduler. Detects the alarm minute, then walks the
// buzzer through RING (toggling tone, auto-stop after RING_SECS), SNOOZE
// (silent for SNOOZE_SECS, at most MAX_SNOOZE times) and back to IDLE.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    alarm_ring_if.slave: time/alarm/key inputs, registered
//          buzzer/ringing/snoozing/snooze_num outputs
module alarm_ring_ctrl #(
  parameter int HALF_CYC    = 25_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alarm_ring_if.slave  bus
);

  localparam int HW = $clog2(HALF_CYC + 1);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_e;

  state_e          state_q, state_d;
  logic            buzzer_q, buzzer_d;
  logic            ringing_q, ringing_d;
  logic            snoozing_q, snoozing_d;
  logic [1:0]      num_q, num_d;
  logic [HW-1:0]   half_q, half_d;
  logic [RW-1:0]   ring_sec_q, ring_sec_d;
  logic [SW-1:0]   snz_left_q, snz_left_d;
  logic            eq, eq_q, trigger;

  // Rising edge of the match gives exactly one trigger per matching minute.
  assign eq      = (bus.cur_hour == bus.alm_hour) && (bus.cur_min == bus.alm_min) &&
                   (bus.cur_sec == 6'd0);
  assign trigger = eq && !eq_q && bus.alm_en && !bus.mode_ring_ad;

  always_comb begin
    state_d    = state_q;
    buzzer_d   = buzzer_q;
    num_d      = num_q;
    half_d     = half_q;
    ring_sec_d = ring_sec_q;
    snz_left_d = snz_left_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = RING;
          num_d      = 2'd0;
          ring_sec_d = '0;
          half_d     = '0;
          buzzer_d   = 1'b1;
        end
      end
      RING: begin
        if (half_q == HW'(HALF_CYC - 1)) begin
          half_d   = '0;
          buzzer_d = ~buzzer_q;
        end else begin
          half_d = half_q + 1'b1;
        end
        if (bus.sec_tick) ring_sec_d = ring_sec_q + 1'b1;
        // stop beats timeout beats snooze
        if (bus.key_stop_flag) begin
          state_d = IDLE;
        end else if (bus.sec_tick && ring_sec_q == RW'(RING_SECS - 1)) begin
          state_d = IDLE;
        end else if (bus.key_snooze_flag && num_q < 2'(MAX_SNOOZE)) begin
          state_d    = SNOOZE;
          num_d      = num_q + 2'd1;
          snz_left_d = SW'(SNOOZE_SECS);
        end
      end
      SNOOZE: begin
        if (bus.sec_tick) snz_left_d = snz_left_q - 1'b1;
        if (bus.key_stop_flag) begin
          state_d = IDLE;
        end else if (bus.sec_tick && snz_left_q == SW'(1)) begin
          state_d    = RING;
          ring_sec_d = '0;
          half_d     = '0;
          buzzer_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disarming overrides everything else.
    if (!bus.alm_en) state_d = IDLE;

    // Tone only sounds while ringing; this also silences on entry to IDLE/SNOOZE.
    if (state_d != RING) buzzer_d = 1'b0;
    ringing_d  = (state_d == RING);
    snoozing_d = (state_d == SNOOZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      num_q      <= 2'd0;
      half_q     <= '0;
      ring_sec_q <= '0;
      snz_left_q <= '0;
      eq_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
      num_q      <= num_d;
      half_q     <= half_d;
      ring_sec_q <= ring_sec_d;
      snz_left_q <= snz_left_d;
      eq_q       <= eq;
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_num = num_q;

endmodule
